// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default widths and Gray-code helpers.
// The helpers work on a wide vector and only consider the low 'w' bits.
package async_fifo_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int GRAY_MAX_W     = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(
        input logic [GRAY_MAX_W-1:0] b,
        input int                    w
    );
        logic [GRAY_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return (b & m) ^ ((b & m) >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int                    w
    );
        logic [GRAY_MAX_W-1:0] b;
        logic                  acc;
        b   = '0;
        acc = 1'b0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            acc  = (i < w) ? (acc ^ g[i]) : 1'b0;
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with synchronous reset to zero; no logic between the stages.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d_i;
            q2_q <= q1_q;
        end
    end

    assign q_o = q2_q;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: read pointer, synchronised write
// pointer, registered empty/almost_empty/occupancy, read data capture and underflow.
module async_fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int DEPTH               = 2 ** ADDR_WIDTH_DEF,
    parameter int ADDR_WIDTH          = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH          = DATA_WIDTH_DEF,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   gray_write_ptr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   gray_read_ptr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    if (DEPTH != 2 ** ADDR_WIDTH) begin : g_depth_check
        $error("async_fifo_rd_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [PTR_W-1:0]      wq2;
    logic [PTR_W-1:0]      rd_bin_q, rd_bin_d;
    logic [PTR_W-1:0]      rd_gray_q, rd_gray_d;
    logic [PTR_W-1:0]      wr_bin;
    logic [PTR_W-1:0]      occ_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  empty_q, empty_d;
    logic                  aempty_q, aempty_d;
    logic [PTR_W-1:0]      count_q;
    logic                  underflow_q;
    logic                  rd_acc;

    sync_2ff #(
        .WIDTH (PTR_W)
    ) u_wptr_sync (
        .clk_i (rd_clk),
        .rst_i (reset),
        .d_i   (gray_write_ptr),
        .q_o   (wq2)
    );

    // Flags are computed from the post-read pointer so the last read empties on its own edge.
    always_comb begin
        rd_acc    = rd_en & ~empty_q;
        rd_bin_d  = rd_bin_q + {{(PTR_W-1){1'b0}}, rd_acc};
        rd_gray_d = PTR_W'(bin2gray(GRAY_MAX_W'(rd_bin_d), PTR_W));
        wr_bin    = PTR_W'(gray2bin(GRAY_MAX_W'(wq2), PTR_W));
        occ_d     = wr_bin - rd_bin_d;
        empty_d   = (rd_gray_d == wq2);
        aempty_d  = (occ_d <= PTR_W'(ALMOST_EMPTY_THRESH));
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_bin_q   <= rd_bin_d;
            rd_gray_q  <= rd_gray_d;
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem_rd_data;
            end
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            count_q  <= occ_d;
            if (rd_en & empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign rd_addr       = rd_bin_q[ADDR_WIDTH-1:0];
    assign gray_read_ptr = rd_gray_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign empty         = empty_q;
    assign almost_empty  = aempty_q;
    assign rd_count      = count_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Self-checking bench for async_fifo_rd_ctrl: vector table for the basic sequence,
// hand-written sequences for wrap, concurrent traffic and mid-stream reset.
module tb_async_fifo_rd_ctrl;

    logic       rd_clk = 1'b0;
    logic       reset;
    logic       rd_en;
    logic [4:0] gray_write_ptr;
    logic [7:0] mem_rd_data;
    logic [3:0] rd_addr;
    logic [4:0] gray_read_ptr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_count;
    logic       underflow;

    logic [7:0] mem [16];
    logic [4:0] wbin;
    logic [7:0] sb [$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 rd_clk = ~rd_clk;

    assign mem_rd_data = mem[rd_addr];

    async_fifo_rd_ctrl #(
        .DEPTH               (16),
        .ADDR_WIDTH          (4),
        .DATA_WIDTH          (8),
        .ALMOST_EMPTY_THRESH (2)
    ) dut (
        .rd_clk         (rd_clk),
        .reset          (reset),
        .rd_en          (rd_en),
        .gray_write_ptr (gray_write_ptr),
        .mem_rd_data    (mem_rd_data),
        .rd_addr        (rd_addr),
        .gray_read_ptr  (gray_read_ptr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .rd_count       (rd_count),
        .underflow      (underflow)
    );

    typedef struct {
        bit         rst;
        bit         rd_en;
        bit         wr;
        logic       e_empty;
        logic       e_ae;
        logic [4:0] e_cnt;
        logic [4:0] e_gray;
        logic [3:0] e_addr;
        logic       e_valid;
        logic       e_uf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_entry(input logic [7:0] d);
        mem[wbin[3:0]] = d;
        sb.push_back(d);
        wbin           = wbin + 5'd1;
        gray_write_ptr = wbin ^ (wbin >> 1);
    endtask

    task automatic model_reset();
        sb.delete();
        wbin           = '0;
        gray_write_ptr = '0;
    endtask

    // Advance one edge, then sample; every valid read is matched against the scoreboard.
    task automatic tick();
        logic [7:0] e;
        @(posedge rd_clk);
        #1;
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e));
            end
        end
    endtask

    task automatic chk_flags(input string tag, input logic e_emp, input logic e_ae, input logic [4:0] e_cnt);
        chk({tag, "_empty"}, 32'(empty), 32'(e_emp));
        chk({tag, "_aempty"}, 32'(almost_empty), 32'(e_ae));
        chk({tag, "_count"}, 32'(rd_count), 32'(e_cnt));
    endtask

    initial begin
        int  nread;
        int  nwr;
        int  occ;
        bit  ok;
        bit  prev_empty;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        reset          = 1'b1;
        rd_en          = 1'b1;
        wbin           = '0;
        gray_write_ptr = '0;

        //              rst rd  wr  emp ae  cnt    gray   addr  vld uf
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'b00000, 4'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00001, 4'd1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00001, 4'd1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00001, 4'd1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst;
            rd_en = vecs[i].rd_en;
            if (vecs[i].rst) model_reset();
            if (vecs[i].wr) write_entry(8'hA5);
            tick();
            chk_flags($sformatf("v%0d", i), vecs[i].e_empty, vecs[i].e_ae, vecs[i].e_cnt);
            chk($sformatf("v%0d_gray", i), 32'(gray_read_ptr), 32'(vecs[i].e_gray));
            chk($sformatf("v%0d_addr", i), 32'(rd_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_uflow", i), 32'(underflow), 32'(vecs[i].e_uf));
        end

        // Full FIFO, then 16 back-to-back reads across the pointer wrap
        reset = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) write_entry(8'h10 + 8'(i));
        chk("full_gptr_stim", 32'(gray_write_ptr), 32'b11000);
        tick();
        chk("full_lag1_empty", 32'(empty), 32'd1);
        tick();
        chk("full_lag2_empty", 32'(empty), 32'd1);
        tick();
        chk_flags("full", 1'b0, 1'b0, 5'd16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_flags($sformatf("wrap%0d", i), (15 - i) == 0, (15 - i) <= 2, 5'(15 - i));
        end
        rd_en = 1'b0;
        chk("wrap_gray", 32'(gray_read_ptr), 32'b11000);
        chk("wrap_addr", 32'(rd_addr), 32'd0);
        chk("wrap_uflow", 32'(underflow), 32'd0);

        // Continuous reads while the writer advances every second cycle
        for (int i = 0; i < 4; i++) write_entry(8'h40 + 8'(i));
        tick();
        tick();
        tick();
        chk_flags("conc_start", 1'b0, 1'b0, 5'd4);
        nread      = 0;
        nwr        = 0;
        prev_empty = empty;
        rd_en      = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if ((c % 2 == 0) && nwr < 12) begin
                write_entry(8'h50 + 8'(nwr));
                nwr++;
            end
            tick();
            if (rd_valid === 1'b1) begin
                chk("conc_read_while_empty", 32'(prev_empty), 32'd0);
                nread++;
            end
            occ = 4 + nwr - nread;
            ok  = (int'(rd_count) <= occ);
            chk("conc_count_le_occ", 32'(ok), 32'd1);
            prev_empty = empty;
        end
        chk("conc_reads", 32'(nread), 32'd16);
        chk("conc_drained", 32'(sb.size()), 32'd0);
        chk_flags("conc_end", 1'b1, 1'b1, 5'd0);
        chk("conc_uflow", 32'(underflow), 32'd1);

        // Reset during a read burst at rd_count=5
        rd_en = 1'b0;
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) write_entry(8'h60 + 8'(i));
        tick();
        tick();
        tick();
        chk_flags("mid_full", 1'b0, 1'b0, 5'd8);
        rd_en = 1'b1;
        tick();
        tick();
        tick();
        chk_flags("mid_burst", 1'b0, 1'b0, 5'd5);
        reset = 1'b1;
        model_reset();
        tick();
        chk_flags("mid_rst", 1'b1, 1'b1, 5'd0);
        chk("mid_rst_gray", 32'(gray_read_ptr), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_addr", 32'(rd_addr), 32'd0);
        reset = 1'b0;
        rd_en = 1'b0;
        tick();
        tick();
        tick();
        chk_flags("mid_after", 1'b1, 1'b1, 5'd0);
        chk("mid_after_uflow", 32'(underflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
Read-side controller for the dual-clock FIFO, living entirely in the rd_clk domain.
- Owns the binary/Gray read pointer and generates the storage read address.
- Synchronises the write-domain Gray write pointer through two flops and derives registered empty, almost_empty and occupancy.
- Captures read data and flags underflow.
- Its gray_read_ptr output is the pointer the write domain consumes for its full flag.

Parameters:
- DEPTH, 16, number of FIFO entries; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 4, storage address width; pointers are ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8, read data width.
- ALMOST_EMPTY_THRESH, 2, almost_empty asserts when occupancy <= this value.

Ports:
- rd_clk  in  1  read-domain clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on rd_clk.
- rd_en  in  1  read request.
- gray_write_ptr  in  ADDR_WIDTH+1  Gray write pointer from the wr_clk domain; asynchronous to rd_clk.
- mem_rd_data  in  DATA_WIDTH  asynchronous-read data from storage at rd_addr.
- rd_addr  out  ADDR_WIDTH  storage read address; equals rd_bin[ADDR_WIDTH-1:0], driven straight from the register.
- gray_read_ptr  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle strobe: rd_data updated this cycle.
- empty  out  1  registered empty flag.
- almost_empty  out  1  registered; rd_count <= ALMOST_EMPTY_THRESH.
- rd_count  out  ADDR_WIDTH+1  registered occupancy estimate, 0..DEPTH.
- underflow  out  1  sticky; set by a read attempted while empty.

Behaviour:
- Reset (synchronous, on rd_clk edge with reset=1) values:
  - rd_bin=0, gray_read_ptr=0, both sync stages=0, rd_addr=0.
  - rd_data=0, rd_valid=0, empty=1, almost_empty=1, rd_count=0, underflow=0.
  - Reset overrides a simultaneous rd_en.
  - Reset mid-operation discards any pending synchronised pointer value.
- Synchroniser: wq1 <= gray_write_ptr; wq2 <= wq1. No logic between the two flops.
- Accept condition: rd_acc = rd_en & ~empty.
- On rd_acc at a rising edge:
  - rd_data <= mem_rd_data (the value at the current rd_addr).
  - rd_bin <= rd_bin+1, modulo 2**(ADDR_WIDTH+1).
  - gray_read_ptr <= bin2gray(rd_bin+1).
  - rd_valid <= 1.
- Otherwise rd_valid <= 0, and rd_bin, gray_read_ptr and rd_data hold.
- Read latency: data appears on rd_data, qualified by rd_valid, one edge after rd_acc.
- Next-state pointer: rd_bin_next = rd_bin + rd_acc; rd_gray_next = bin2gray(rd_bin_next).
- empty <= (rd_gray_next == wq2). Consequences:
  - Reading the last entry sets empty on the same edge that advances the pointer.
  - A write-pointer change reaches empty 3 rd_clk edges after it appears on gray_write_ptr (wq1, wq2, empty).
- rd_count <= gray2bin(wq2) - rd_bin_next, taken modulo 2**(ADDR_WIDTH+1).
- almost_empty <= (that same difference <= ALMOST_EMPTY_THRESH).
- Underflow:
  - rd_en & empty sets underflow, which stays set until reset.
  - Pointer, rd_data and rd_valid are unaffected by the rejected read.
- Wrap-around:
  - Pointer wraps after 2*DEPTH reads; the MSB toggles every DEPTH reads.
  - rd_addr wraps every DEPTH reads.
  - rd_count stays correct across the wrap because the subtraction is modular.
- Full FIFO: rd_count = DEPTH is legal, with wq2 MSB differing from the read pointer MSB and lower bits equal.
- Simultaneous write-pointer advance and read: both enter the next-state equations, so empty and rd_count reflect both.
- Conservatism: empty and rd_count are pessimistic by up to the synchroniser lag. Never optimistic.

Decomposition:
- Package async_fifo_pkg:
  - bin2gray and gray2bin functions, parameterised by width.
  - Default ADDR_WIDTH and DATA_WIDTH constants, shared with the write-side and status blocks.
- Sub-module sync_2ff, parameter WIDTH: reset-to-0 two-flop synchroniser. Instantiated once here and reused by the write side.

Test Plan:
- Reset:
  - Stimulus: hold reset 2 cycles with rd_en=1 and gray_write_ptr=00000.
  - Response: empty=1, almost_empty=1, rd_count=0, gray_read_ptr=00000, rd_valid=0, underflow=0.
- Single entry:
  - Stimulus: gray_write_ptr=00001.
  - Response: empty falls on the 3rd rd_clk edge with rd_count=1.
  - Stimulus: then rd_en=1 for one cycle with mem_rd_data=8'hA5.
  - Response: next cycle rd_data=8'hA5, rd_valid=1, gray_read_ptr=00001, rd_addr=1, empty=1, rd_count=0.
- Underflow:
  - Stimulus: rd_en=1 while empty.
  - Response: underflow=1 and stays 1; gray_read_ptr unchanged; rd_valid=0.
  - Stimulus: then reset.
  - Response: underflow=0.
- Full and wrap:
  - Stimulus: gray_write_ptr=11000 (binary 16), then 16 back-to-back reads.
  - Response: rd_count=16 before reading, and decrements by 1 per read to 0. almost_empty asserts when rd_count reaches 2. Final gray_read_ptr=11000, rd_addr=0, empty=1.
- Concurrent:
  - Stimulus: with 4 entries, read continuously while gray_write_ptr advances one step per 2 rd_clk cycles.
  - Response: data order preserved; no read accepted while empty; rd_count never exceeds the true occupancy.
- Reset mid-stream:
  - Stimulus: assert reset during a read burst at rd_count=5.
  - Response: the next edge gives empty=1, rd_count=0, gray_read_ptr=0, rd_valid=0.
